// File: rtl/i_o_uart_pkg.sv
// rtl/i_o_uart_pkg.sv - shared types and constants for the UART transmitter
package i_o_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_ODD,
        PAR_EVEN
    } uart_parity_t;

    localparam int DEFAULT_CLKS_PER_BIT = 868;

    // Even parity is the plain XOR of the payload; odd parity inverts it.
    function automatic logic parity_for(input logic xor_val, input uart_parity_t mode);
        return (mode == PAR_ODD) ? ~xor_val : xor_val;
    endfunction

endpackage

// File: rtl/i_o_baud_tick.sv
// rtl/i_o_baud_tick.sv - bit-period counter with synchronous restart
module i_o_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    output logic tick_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Tick marks the last cycle of a bit period, not gated by restart.
    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/i_o_uart_tx.sv
// rtl/i_o_uart_tx.sv - buffered UART transmitter with configurable framing
module i_o_uart_tx
    import i_o_uart_pkg::*;
#(
    parameter int           DATA_BITS    = 8,
    parameter int           CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter uart_parity_t PARITY       = PAR_NONE,
    parameter int           STOP_BITS    = 1,
    parameter int           FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          io_output_value,
    input  logic                          io_output_trigger,
    output logic                          io_output_ready_trigger,
    output logic                          RXD,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        rd_ptr_q;
    logic [LW-1:0]        level_q;
    logic [LW-1:0]        level_d;
    logic                 ready_q;

    uart_tx_state_t       state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 rxd_q;
    logic [3:0]           bit_cnt_q;

    logic tick;
    logic push;
    logic pop;
    logic frame_done;

    assign push       = io_output_trigger && ready_q;
    assign frame_done = (state_q == ST_STOP) && tick && (bit_cnt_q == LAST_STOP);
    assign pop        = (level_q != '0) && ((state_q == ST_IDLE) || frame_done);

    i_o_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .restart_i (pop),
        .tick_o    (tick)
    );

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
            ready_q <= (level_d < DEPTH_L);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= io_output_value;
        end
    end

    // The frame is latched into shift_q at pop, so later pushes cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rxd_q     <= 1'b1;
            shift_q   <= '0;
            par_q     <= 1'b0;
            bit_cnt_q <= '0;
        end else if (pop) begin
            state_q   <= ST_START;
            rxd_q     <= 1'b0;
            shift_q   <= mem_q[rd_ptr_q];
            par_q     <= parity_for(^mem_q[rd_ptr_q], PARITY);
            bit_cnt_q <= '0;
        end else if (tick) begin
            case (state_q)
                ST_START: begin
                    state_q   <= ST_DATA;
                    rxd_q     <= shift_q[0];
                    shift_q   <= shift_q >> 1;
                    bit_cnt_q <= '0;
                end
                ST_DATA: begin
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_q <= '0;
                        if (PARITY != PAR_NONE) begin
                            state_q <= ST_PARITY;
                            rxd_q   <= par_q;
                        end else begin
                            state_q <= ST_STOP;
                            rxd_q   <= 1'b1;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        rxd_q     <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                    end
                end
                ST_PARITY: begin
                    state_q   <= ST_STOP;
                    rxd_q     <= 1'b1;
                    bit_cnt_q <= '0;
                end
                ST_STOP: begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_q <= ST_IDLE;
                        rxd_q   <= 1'b1;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    assign io_output_ready_trigger = ready_q;
    assign RXD                     = rxd_q;
    assign fifo_level              = level_q;
    assign busy                    = (state_q != ST_IDLE) || (level_q != '0);

endmodule

// File: tb/tb_i_o_uart_tx.sv
// tb/tb_i_o_uart_tx.sv - scoreboard bench for the UART transmitter
module tb_i_o_uart_tx;
    import i_o_uart_pkg::*;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] val0 = '0;
    logic [6:0] val1 = '0;
    logic [6:0] val2 = '0;
    logic [2:0] trig = '0;
    logic [2:0] rdy;
    logic [2:0] rxd;
    logic [2:0] busy;
    logic [2:0] lvl0;
    logic [2:0] lvl1;
    logic [2:0] lvl2;

    logic exp_bits [$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    i_o_uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .rst(rst), .io_output_value(val0), .io_output_trigger(trig[0]),
        .io_output_ready_trigger(rdy[0]), .RXD(rxd[0]), .busy(busy[0]), .fifo_level(lvl0));

    i_o_uart_tx #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .PARITY(PAR_EVEN), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7e2 (
        .clk(clk), .rst(rst), .io_output_value(val1), .io_output_trigger(trig[1]),
        .io_output_ready_trigger(rdy[1]), .RXD(rxd[1]), .busy(busy[1]), .fifo_level(lvl1));

    i_o_uart_tx #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .PARITY(PAR_ODD), .STOP_BITS(1), .FIFO_DEPTH(4)) u_7o1 (
        .clk(clk), .rst(rst), .io_output_value(val2), .io_output_trigger(trig[2]),
        .io_output_ready_trigger(rdy[2]), .RXD(rxd[2]), .busy(busy[2]), .fifo_level(lvl2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_frame(input int nbits, input uart_parity_t par,
                                        input int nstop, input logic [8:0] v);
        logic p;
        p = 1'b0;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            exp_bits.push_back(v[i]);
            p = p ^ v[i];
        end
        if (par == PAR_EVEN) exp_bits.push_back(p);
        if (par == PAR_ODD)  exp_bits.push_back(~p);
        for (int i = 0; i < nstop; i++) exp_bits.push_back(1'b1);
    endfunction

    task automatic push0(input logic [7:0] v, input bit accepted);
        val0    = v;
        trig[0] = 1'b1;
        if (accepted) model_frame(8, PAR_NONE, 1, {1'b0, v});
        @(negedge clk);
        trig[0] = 1'b0;
    endtask

    // Every cycle of every expected bit is sampled, so gaps or stretched bits show up.
    task automatic check_stream(input int d, input int nbits, input string tag);
        int         guard;
        logic [3:0] samp;
        logic       b;
        guard = 0;
        while (rxd[d] !== 1'b0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_start_seen"}, 32'(rxd[d]), 32'd0);
        for (int i = 0; i < nbits; i++) begin
            b = (exp_bits.size() != 0) ? exp_bits.pop_front() : 1'bx;
            for (int j = 0; j < CPB; j++) begin
                samp[j] = rxd[d];
                @(negedge clk);
            end
            chk($sformatf("%s_bit%0d", tag, i), 32'(samp), 32'({4{b}}));
        end
    endtask

    task automatic check_idle(input int d, input string tag);
        chk({tag, "_rxd_idle"}, 32'(rxd[d]), 32'd1);
        chk({tag, "_busy_idle"}, 32'(busy[d]), 32'd0);
        chk({tag, "_ready_idle"}, 32'(rdy[d]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) check_idle(d, $sformatf("reset%0d", d));
        chk("reset_level0", 32'(lvl0), 32'd0);
        chk("reset_level1", 32'(lvl1), 32'd0);
        chk("reset_level2", 32'(lvl2), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 8N1 single byte with exact start latency
        push0(8'hA5, 1'b1);
        chk("a5_level_after_push", 32'(lvl0), 32'd1);
        chk("a5_busy_after_push", 32'(busy[0]), 32'd1);
        chk("a5_rxd_before_pop", 32'(rxd[0]), 32'd1);
        @(negedge clk);
        chk("a5_start_after_pop", 32'(rxd[0]), 32'd0);
        chk("a5_level_after_pop", 32'(lvl0), 32'd0);
        check_stream(0, 10, "a5");
        check_idle(0, "a5_end");

        // 7E2 and 7O1 with payload 0x55
        val1 = 7'h55; trig[1] = 1'b1;
        model_frame(7, PAR_EVEN, 2, 9'h055);
        @(negedge clk);
        trig[1] = 1'b0;
        check_stream(1, 11, "e2");
        check_idle(1, "e2_end");

        val2 = 7'h55; trig[2] = 1'b1;
        model_frame(7, PAR_ODD, 1, 9'h055);
        @(negedge clk);
        trig[2] = 1'b0;
        check_stream(2, 10, "o1");
        check_idle(2, "o1_end");

        // Full FIFO: five accepted, sixth dropped, all sent back-to-back
        fork
            begin
                push0(8'h11, 1'b1);
                push0(8'h22, 1'b1);
                push0(8'h33, 1'b1);
                push0(8'h44, 1'b1);
                push0(8'h55, 1'b1);
                chk("full_level", 32'(lvl0), 32'd4);
                chk("full_ready_low", 32'(rdy[0]), 32'd0);
                push0(8'h66, 1'b0);
                chk("full_drop_level", 32'(lvl0), 32'd4);
                chk("full_drop_ready", 32'(rdy[0]), 32'd0);
            end
            check_stream(0, 50, "full");
        join
        check_idle(0, "full_end");
        chk("full_end_level", 32'(lvl0), 32'd0);

        // Simultaneous push and pop at level 2
        fork
            begin
                push0(8'hC3, 1'b1);
                push0(8'h3C, 1'b1);
                push0(8'h81, 1'b1);
                chk("pp_level_pre", 32'(lvl0), 32'd2);
                repeat (38) @(negedge clk);
                chk("pp_level_hold", 32'(lvl0), 32'd2);
                push0(8'h7E, 1'b1);
                chk("pp_level_after", 32'(lvl0), 32'd2);
            end
            check_stream(0, 40, "pp");
        join
        check_idle(0, "pp_end");

        // Reset in the middle of 0xFF's data bits, with a competing push
        push0(8'hFF, 1'b0);
        repeat (10) @(negedge clk);
        chk("rst_mid_data_rxd", 32'(rxd[0]), 32'd1);
        chk("rst_mid_busy", 32'(busy[0]), 32'd1);
        rst = 1'b1; val0 = 8'h42; trig[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0; trig[0] = 1'b0;
        check_idle(0, "rst_abort");
        chk("rst_abort_level", 32'(lvl0), 32'd0);
        repeat (6) @(negedge clk);
        chk("rst_quiet_rxd", 32'(rxd[0]), 32'd1);
        chk("rst_quiet_busy", 32'(busy[0]), 32'd0);
        push0(8'h00, 1'b1);
        check_stream(0, 10, "zero");
        check_idle(0, "zero_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/i_o_uart_tx.md
I_O_UART_TX -- requirements
Module: i_o_uart_tx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: payload bits per frame, legal 5..9.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 868: clk cycles per serial bit, legal >= 2.
REQ-003 SHALL have parameter PARITY, default PAR_NONE: parity mode, one of PAR_NONE / PAR_ODD / PAR_EVEN.
REQ-004 SHALL have parameter STOP_BITS, default 1: stop bits per frame, legal 1..2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: transmit buffer entries, power of two, >= 2.
REQ-006 SHALL have ports in this order and form:
- clk  in  1  sole clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- io_output_value  in  DATA_BITS  byte to send.
- io_output_trigger  in  1  write request.
- io_output_ready_trigger  out  1  FIFO can accept.
- RXD  out  1  serial line to host, idle high.
- busy  out  1  frame in flight or FIFO non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries.

Function
REQ-007 SHALL push io_output_value into the FIFO on a cycle where io_output_trigger && io_output_ready_trigger; no other push.
REQ-008 SHALL drive io_output_ready_trigger = (fifo_level < FIFO_DEPTH), registered; trigger while not ready is dropped silently.
REQ-009 SHALL run FSM states IDLE, START, DATA, PARITY, STOP.
REQ-010 SHALL pop the FIFO head in IDLE when non-empty, entering START; RXD goes 0 on the next clk edge.
REQ-011 SHALL hold each line bit for exactly CLKS_PER_BIT cycles; the bit counter restarts at each START entry (no free-running baud phase).
REQ-012 SHALL send DATA_BITS payload bits LSB first.
REQ-013 SHALL transition DATA->PARITY when PARITY != PAR_NONE, else DATA->STOP.
REQ-014 SHALL send the parity bit as XOR of the payload for PAR_EVEN and as its inverse for PAR_ODD.
REQ-015 SHALL send STOP_BITS stop periods at RXD=1.
REQ-016 SHALL pop the next FIFO entry in the same cycle the last stop period ends if the FIFO is non-empty, so frames are back-to-back with no idle gap.
REQ-017 SHALL, on a simultaneous push and pop, leave fifo_level unchanged and keep data order.
REQ-018 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.
REQ-019 SHALL set busy = (state != IDLE) || (fifo_level != 0).
REQ-020 SHALL NOT alter a frame already in flight because of new pushes.

Reset
REQ-021 SHALL, when rst is high at a clk edge, set state=IDLE, RXD=1, FIFO empty, fifo_level=0, io_output_ready_trigger=1, busy=0, and clear the bit and baud counters.
REQ-022 SHALL abort any frame in progress on reset, with RXD=1 on the next edge.
REQ-023 SHALL give rst priority over a simultaneous push.
REQ-024 SHALL NOT rely on initial blocks for functional reset.

Structure
REQ-025 SHALL place enum uart_tx_state_t (the five states), enum uart_parity_t (PAR_NONE/PAR_ODD/PAR_EVEN) and constant DEFAULT_CLKS_PER_BIT in shared package i_o_uart_pkg.
REQ-026 SHALL instantiate one sub-module, i_o_baud_tick: a CLKS_PER_BIT counter with a synchronous restart input that pulses once per bit period.
REQ-027 SHALL keep the FIFO inline as a register array.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless stated)
REQ-028 SHALL cover 8N1, push 0xA5 -> RXD sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; start bit on the cycle after the pop.
REQ-029 SHALL cover 7E2, push 0x55 -> seven data bits LSB first, parity 0, two stop bits; 7O1, push 0x55 -> parity 1.
REQ-030 SHALL cover full FIFO: push 5 bytes back-to-back -> first popped at once, 4 buffered, ready low; a 6th trigger is dropped; bytes are sent in order with no gaps.
REQ-031 SHALL cover simultaneous push and pop at fifo_level=2 -> fifo_level stays 2.
REQ-032 SHALL cover reset mid-DATA of 0xFF -> RXD=1 and busy=0 next edge; FIFO empty; next pushed 0x00 is sent correctly.
